// File: rtl/wb_tlc_cpld_pkt_fifo_if.sv
// Completion-builder write port plus PCIe core transmit port of the CplD packet FIFO.
interface wb_tlc_cpld_pkt_fifo_if #(
  parameter int c_DATA_WIDTH    = 64,
  parameter int c_ADDR_WIDTH    = 9,
  parameter int c_PKT_CNT_WIDTH = 8
);
  logic [c_DATA_WIDTH-1:0]    din;
  logic                       din_sop;
  logic                       din_eop;
  logic                       din_dwen;
  logic                       din_wen;
  logic                       din_full;
  logic                       din_drop;
  logic [c_DATA_WIDTH-1:0]    tx_data;
  logic                       tx_st;
  logic                       tx_end;
  logic                       tx_dwen;
  logic                       tx_req;
  logic                       tx_rdy;
  logic                       tx_val;
  logic [c_PKT_CNT_WIDTH-1:0] pkt_cnt;
  logic [c_ADDR_WIDTH:0]      fifo_level;

  modport master (
    output din, din_sop, din_eop, din_dwen, din_wen, tx_rdy, tx_val,
    input  din_full, din_drop, tx_data, tx_st, tx_end, tx_dwen, tx_req, pkt_cnt, fifo_level
  );

  modport slave (
    input  din, din_sop, din_eop, din_dwen, din_wen, tx_rdy, tx_val,
    output din_full, din_drop, tx_data, tx_st, tx_end, tx_dwen, tx_req, pkt_cnt, fifo_level
  );
endinterface

// File: rtl/wb_tlc_cpld_pkt_fifo.sv
// Store-and-forward CplD FIFO: only committed TLPs are offered; aborted or overflowed packets are rewound.
// First beat on the tx_val cycle after the tx_rdy grant; tx_val low freezes the read side, din_full signals overflow.
module wb_tlc_cpld_pkt_fifo #(
  parameter int c_DATA_WIDTH    = 64,
  parameter int c_ADDR_WIDTH    = 9,
  parameter int c_PKT_CNT_WIDTH = 8
) (
  input  logic                    clk_125,
  input  logic                    rstn,
  wb_tlc_cpld_pkt_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << c_ADDR_WIDTH;

  typedef logic [c_ADDR_WIDTH:0] ptr_t;

  typedef struct packed {
    logic                    dwen;
    logic                    sop;
    logic                    eop;
    logic [c_DATA_WIDTH-1:0] data;
  } word_t;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DISCARD} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_XFER} rd_state_t;

  word_t                      mem [DEPTH];
  word_t                      head;
  ptr_t                       wr_ptr, commit_ptr, rd_ptr, wr_addr, level;
  wr_state_t                  wr_state;
  rd_state_t                  rd_state;
  logic [c_PKT_CNT_WIDTH-1:0] pkt_cnt_q;
  logic [c_DATA_WIDTH-1:0]    tx_data_q;
  logic                       tx_st_q, tx_end_q, tx_dwen_q, tx_req_q, drop_q;
  logic                       full, wr_en, abort, overflow, commit, pkt_done;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == ptr_t'(DEPTH));
  assign overflow = bus.din_wen && full;
  assign commit   = wr_en && bus.din_eop;
  assign pkt_done = bus.tx_val && (rd_state == R_XFER) && tx_end_q;
  assign head     = mem[rd_ptr[c_ADDR_WIDTH-1:0]];

  // A sop inside an open packet restarts it at commit_ptr in the same cycle.
  always_comb begin
    wr_en   = 1'b0;
    abort   = 1'b0;
    wr_addr = wr_ptr;
    if (bus.din_wen && !full) begin
      if (wr_state == W_PKT) begin
        wr_en = 1'b1;
        if (bus.din_sop) begin
          abort   = 1'b1;
          wr_addr = commit_ptr;
        end
      end else begin
        wr_en = bus.din_sop;
      end
    end
  end

  always_ff @(posedge clk_125) begin
    if (wr_en) mem[wr_addr[c_ADDR_WIDTH-1:0]] <= {bus.din_dwen, bus.din_sop, bus.din_eop, bus.din};
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      wr_state   <= W_IDLE;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (overflow) begin
        wr_ptr <= commit_ptr;
        if (bus.din_eop) begin
          drop_q   <= 1'b1;
          wr_state <= W_IDLE;
        end else begin
          wr_state <= W_DISCARD;
        end
      end else if (wr_en) begin
        wr_ptr <= wr_addr + 1'b1;
        drop_q <= abort;
        if (bus.din_eop) begin
          commit_ptr <= wr_addr + 1'b1;
          wr_state   <= W_IDLE;
        end else begin
          wr_state <= W_PKT;
        end
      end else if (bus.din_wen && bus.din_eop && wr_state == W_DISCARD) begin
        drop_q   <= 1'b1;
        wr_state <= W_IDLE;
      end
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_q <= '0;
    end else begin
      case ({commit, pkt_done})
        2'b10:   if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 1'b1;
        2'b01:   if (pkt_cnt_q != '0) pkt_cnt_q <= pkt_cnt_q - 1'b1;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      rd_state  <= R_IDLE;
      rd_ptr    <= '0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      tx_st_q   <= 1'b0;
      tx_end_q  <= 1'b0;
      tx_dwen_q <= 1'b0;
    end else if (bus.tx_val) begin
      case (rd_state)
        R_IDLE: begin
          if (pkt_cnt_q != '0) begin
            rd_state <= R_REQ;
            tx_req_q <= 1'b1;
          end
        end
        R_REQ: begin
          if (bus.tx_rdy) begin
            rd_state  <= R_XFER;
            tx_req_q  <= 1'b0;
            rd_ptr    <= rd_ptr + 1'b1;
            tx_data_q <= head.data;
            tx_st_q   <= head.sop;
            tx_end_q  <= head.eop;
            tx_dwen_q <= head.dwen;
          end
        end
        R_XFER: begin
          if (tx_end_q) begin
            rd_state  <= R_IDLE;
            tx_data_q <= '0;
            tx_st_q   <= 1'b0;
            tx_end_q  <= 1'b0;
            tx_dwen_q <= 1'b0;
          end else begin
            rd_ptr    <= rd_ptr + 1'b1;
            tx_data_q <= head.data;
            tx_st_q   <= head.sop;
            tx_end_q  <= head.eop;
            tx_dwen_q <= head.dwen;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign bus.din_full   = full;
  assign bus.din_drop   = drop_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_st      = tx_st_q;
  assign bus.tx_end     = tx_end_q;
  assign bus.tx_dwen    = tx_dwen_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.pkt_cnt    = pkt_cnt_q;
  assign bus.fifo_level = level;
endmodule
